dsp_mac_sequencer: RTL

Sequencer that drives one `DSP_project` slice (A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, CARRYOUTREG=1, B_INPUT="DIRECT") to compute unsigned dot products of streamed 18-bit operand pairs. It accepts a length and a stream of (a, b) pairs over a valid/ready handshake. It issues the per-cycle OPMODE sequence so that P accumulates in place, and returns the 48-bit sum with a sticky overflow flag over a second valid/ready handshake. It sits between the operand-fetch logic and the DSP slice.

---
 rtl/dsp_seq_pkg.sv | 32 +++
 rtl/dsp_tag_pipe.sv | 39 +++
 rtl/dsp_mac_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dsp_seq_pkg.sv
// ---------------------------------------------------------------------------
// dsp_seq_pkg
// Shared types and constants for the DSP MAC sequencer.
//   state_e   : sequencer FSM states
//   OP_*      : OPMODE words issued to the DSP slice
//               (bits [1:0] = X mux, [3:2] = Z mux, upper bits = 0:
//                no pre-adder, CIN = 0, post-adder adds)
//   TAG_DEPTH : depth of the {valid, last} tag pipeline
//   tag_t     : one tag pipeline entry
// ---------------------------------------------------------------------------
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [7:0] OP_FIRST = 8'h01;  // Z=0, X=M : P <= M
  localparam logic [7:0] OP_ACC   = 8'h09;  // Z=P, X=M : P <= P + M
  localparam logic [7:0] OP_HOLD  = 8'h08;  // Z=P, X=0 : P <= P
  localparam logic [7:0] OP_RST   = 8'h00;  // Z=0, X=0

  localparam int TAG_DEPTH = 2;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

endpackage

// File: rtl/dsp_tag_pipe.sv
// ---------------------------------------------------------------------------
// dsp_tag_pipe
// Fixed-depth shift register of {valid, last} tags. A tag enters every clock
// (an empty tag when nothing was issued) and leaves DEPTH edges later, lined
// up with the DSP slice result it describes.
//   clk   : clock
//   rst   : asynchronous, active-high reset (clears all stages)
//   tag_i : tag entering stage 1
//   tag_o : tag leaving the last stage
// ---------------------------------------------------------------------------
module dsp_tag_pipe
  import dsp_seq_pkg::*;
#(
  parameter int DEPTH = TAG_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t [DEPTH-1:0] stage_q;

  // NOTE: the tag stages are control, not data storage: a stale valid bit
  // would fake a result after reset, so every stage is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// ---------------------------------------------------------------------------
// dsp_mac_sequencer
// Drives one DSP slice (A1/B1, M, P, OPMODE and CARRYOUT registered) to
// accumulate an unsigned dot product of streamed 18-bit operand pairs in P.
//   clk, RST              : clock, asynchronous active-high reset
//   start, len            : job request (sampled in IDLE only), element count
//   busy                  : high outside IDLE
//   in_valid/in_ready     : operand handshake, in_a/in_b operand pair
//   out_valid/out_ready   : result handshake
//   result, overflow      : 48-bit sum (mod 2^48), sticky CARRYOUT flag
//   dsp_A, dsp_B          : operands straight through to the slice
//   dsp_OPMODE, dsp_CE    : slice control (CE tied high)
//   dsp_P, dsp_CARRYOUT   : slice outputs
// ---------------------------------------------------------------------------
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [47:0]      result,
  output logic             overflow,
  output logic [17:0]      dsp_A,
  output logic [17:0]      dsp_B,
  output logic [7:0]       dsp_OPMODE,
  output logic             dsp_CE,
  input  logic [47:0]      dsp_P,
  input  logic             dsp_CARRYOUT
);

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count_q;
  logic             busy_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [47:0]      result_q;
  logic             ovf_q;
  logic [7:0]       opmode_q;
  tag_t             issue_q;   // tag of the element whose OPMODE went out this edge
  tag_t             tag_s2;    // tag whose element is now reflected in dsp_P

  logic accept;
  logic last_el;

  // in_ready_q is only ever high in RUN while count < len.
  assign accept  = (state_q == ST_RUN) && in_valid && in_ready_q;
  assign last_el = (count_q == (len_q - LEN_W'(1)));

  // The issue register lines the tag up with the slice's OPMODE register; the
  // two tag stages then cover the M and P registers, so tag_s2 is valid in the
  // cycle after P has absorbed that element.
  dsp_tag_pipe #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_pipe (
    .clk  (clk),
    .rst  (RST),
    .tag_i(issue_q),
    .tag_o(tag_s2)
  );

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      opmode_q    <= OP_RST;
      issue_q     <= '0;
    end else begin
      // NOTE: OPMODE and the issue tag are reloaded every edge; these defaults
      // cover every cycle without an accept, so no path can leave them stale.
      opmode_q <= OP_HOLD;
      issue_q  <= '0;

      if (tag_s2.valid) begin
        ovf_q <= ovf_q | dsp_CARRYOUT;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q   <= len;
            count_q <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            if (len == '0) begin
              // Empty job: report a zero result without touching the slice.
              result_q    <= '0;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          if (accept) begin
            // The first element overwrites P, later ones add onto it.
            opmode_q <= (count_q == '0) ? OP_FIRST : OP_ACC;
            count_q  <= count_q + LEN_W'(1);
            issue_q  <= '{valid: 1'b1, last: last_el};
            if (last_el) begin
              in_ready_q <= 1'b0;
              state_q    <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          if (tag_s2.valid && tag_s2.last) begin
            result_q    <= dsp_P;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign overflow   = ovf_q;
  assign dsp_A      = in_a;
  assign dsp_B      = in_b;
  assign dsp_OPMODE = opmode_q;
  assign dsp_CE     = 1'b1;

endmodule
